// File: rtl/circle_set_counter.sv
// Scans a GRID x GRID lattice and counts points satisfying a set expression over
// three circles. Two-stage pipeline: squared distances, then membership/accumulate.
module circle_set_counter #(
    parameter int unsigned GRID  = 8,
    parameter int unsigned CW    = 4,
    parameter int unsigned CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [CW-1:0]    cx_a,
    input  logic [CW-1:0]    cy_a,
    input  logic [CW-1:0]    r_a,
    input  logic [CW-1:0]    cx_b,
    input  logic [CW-1:0]    cy_b,
    input  logic [CW-1:0]    r_b,
    input  logic [CW-1:0]    cx_c,
    input  logic [CW-1:0]    cy_c,
    input  logic [CW-1:0]    r_c,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] candidate
);

    localparam int unsigned SW = 2 * CW + 1;
    localparam logic [CW-1:0] GridC = CW'(GRID);
    localparam logic [CW-1:0] OneC  = CW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StFlush,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [CW-1:0]    x_q, x_d;
    logic [CW-1:0]    y_q, y_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [1:0]       mode_q, mode_d;

    // Latched circle parameters, index 0/1/2 = A/B/C.
    logic [CW-1:0] cx_q [3];
    logic [CW-1:0] cx_d [3];
    logic [CW-1:0] cy_q [3];
    logic [CW-1:0] cy_d [3];
    logic [CW-1:0] r_q  [3];
    logic [CW-1:0] r_d  [3];

    // Stage-1 registers: squared distance per circle plus a point-valid flag.
    logic [SW-1:0] s_q [3];
    logic [SW-1:0] s_d [3];
    logic          v1_q, v1_d;

    logic [2:0] in_c;
    logic       hit;

    function automatic logic [CW-1:0] abs_diff(input logic [CW-1:0] p, input logic [CW-1:0] c);
        abs_diff = (p >= c) ? (p - c) : (c - p);
    endfunction

    function automatic logic [2*CW-1:0] square(input logic [CW-1:0] d);
        square = {{CW{1'b0}}, d} * {{CW{1'b0}}, d};
    endfunction

    // Stage 1: squared Euclidean distance of the issued point to each centre.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            s_d[k] = {1'b0, square(abs_diff(x_q, cx_q[k]))}
                   + {1'b0, square(abs_diff(y_q, cy_q[k]))};
        end
    end

    // Stage 2: inclusive membership test and set expression.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            in_c[k] = (s_q[k] <= {1'b0, square(r_q[k])});
        end
        hit = 1'b0;
        unique case (mode_q)
            2'b00: hit = in_c[0];
            2'b01: hit = in_c[0] & in_c[1];
            2'b10: hit = in_c[0] ^ in_c[1];
            2'b11: hit = (in_c == 3'b011) || (in_c == 3'b101) || (in_c == 3'b110);
            default: hit = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        cand_d  = cand_q;
        acc_d   = acc_q;
        mode_d  = mode_q;
        for (int k = 0; k < 3; k++) begin
            cx_d[k] = cx_q[k];
            cy_d[k] = cy_q[k];
            r_d[k]  = r_q[k];
        end
        v1_d = (state_q == StScan);

        if (v1_q) begin
            acc_d = acc_q + CNT_W'(hit);
        end

        unique case (state_q)
            StIdle: begin
                if (en) begin
                    mode_d  = mode;
                    cx_d[0] = cx_a;
                    cy_d[0] = cy_a;
                    r_d[0]  = r_a;
                    cx_d[1] = cx_b;
                    cy_d[1] = cy_b;
                    r_d[1]  = r_b;
                    cx_d[2] = cx_c;
                    cy_d[2] = cy_c;
                    r_d[2]  = r_c;
                    busy_d  = 1'b1;
                    acc_d   = '0;
                    x_d     = OneC;
                    y_d     = OneC;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (x_q == GridC) begin
                    x_d = OneC;
                    if (y_q == GridC) begin
                        state_d = StFlush;
                    end else begin
                        y_d = y_q + OneC;
                    end
                end else begin
                    x_d = x_q + OneC;
                end
            end
            StFlush: begin
                // Last point reaches the accumulator on this edge.
                state_d = StDone;
            end
            StDone: begin
                cand_d  = acc_q;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            cand_q  <= '0;
            acc_q   <= '0;
            mode_q  <= '0;
            v1_q    <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                cx_q[k] <= '0;
                cy_q[k] <= '0;
                r_q[k]  <= '0;
                s_q[k]  <= '0;
            end
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            cand_q  <= cand_d;
            acc_q   <= acc_d;
            mode_q  <= mode_d;
            v1_q    <= v1_d;
            for (int k = 0; k < 3; k++) begin
                cx_q[k] <= cx_d[k];
                cy_q[k] <= cy_d[k];
                r_q[k]  <= r_d[k];
                s_q[k]  <= s_d[k];
            end
        end
    end

    assign busy      = busy_q;
    assign valid     = valid_q;
    assign candidate = cand_q;

endmodule

// File: tb/tb_circle_set_counter.sv
// Directed bench for circle_set_counter: hand-counted lattice results, handshake,
// reset abort and result hold.
module tb_circle_set_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] cx_a, cy_a, r_a, cx_b, cy_b, r_b, cx_c, cy_c, r_c;
    logic       busy;
    logic       valid;
    logic [6:0] candidate;

    int checks   = 0;
    int failures = 0;

    circle_set_counter #(
        .GRID (8),
        .CW   (4),
        .CNT_W(7)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .cx_a     (cx_a),
        .cy_a     (cy_a),
        .r_a      (r_a),
        .cx_b     (cx_b),
        .cy_b     (cy_b),
        .r_b      (r_b),
        .cx_c     (cx_c),
        .cy_c     (cy_c),
        .r_c      (r_c),
        .busy     (busy),
        .valid    (valid),
        .candidate(candidate)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present a configuration with en high across one rising edge (E0).
    task automatic start(input logic [1:0] m,
                         input logic [3:0] ax, input logic [3:0] ay, input logic [3:0] ar,
                         input logic [3:0] bx, input logic [3:0] by, input logic [3:0] br,
                         input logic [3:0] qx, input logic [3:0] qy, input logic [3:0] qr);
        mode = m;
        cx_a = ax; cy_a = ay; r_a = ar;
        cx_b = bx; cy_b = by; r_b = br;
        cx_c = qx; cy_c = qy; r_c = qr;
        en   = 1'b1;
        @(posedge clk);
        #1;
        en   = 1'b0;
    endtask

    // Counts edges after E0 until valid is seen; poke_at >= 0 pulses a bogus en mid-scan.
    task automatic wait_valid(input int poke_at, output int n);
        n = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (n == poke_at + 1) en = 1'b0;
            if (valid) break;
            if (n == poke_at) begin
                en   = 1'b1;
                mode = 2'b11;
                cx_a = 4'd0; cy_a = 4'd0; r_a = 4'd15;
            end
        end
        en = 1'b0;
    endtask

    task automatic run_case(input string tag, input logic [1:0] m,
                            input logic [3:0] ax, input logic [3:0] ay, input logic [3:0] ar,
                            input logic [3:0] bx, input logic [3:0] by, input logic [3:0] br,
                            input logic [3:0] qx, input logic [3:0] qy, input logic [3:0] qr,
                            input int exp_cnt);
        int n;
        start(m, ax, ay, ar, bx, by, br, qx, qy, qr);
        wait_valid(-5, n);
        check({tag, "_lat"}, n, 66);
        check({tag, "_cnt"}, candidate, exp_cnt);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, valid, 0);
    endtask

    initial begin
        int  n;
        bit  saw_valid;
        rst  = 1'b1;
        en   = 1'b0;
        mode = 2'b00;
        cx_a = 0; cy_a = 0; r_a = 0;
        cx_b = 0; cy_b = 0; r_b = 0;
        cx_c = 0; cy_c = 0; r_c = 0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_cand", candidate, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Mode 00 with explicit busy/latency checks.
        start(2'b00, 4, 4, 2, 0, 0, 0, 0, 0, 0);
        check("m00_busy_hi", busy, 1);
        wait_valid(-5, n);
        check("m00_lat", n, 66);
        check("m00_cnt", candidate, 13);
        check("m00_busy_lo", busy, 0);
        @(posedge clk);
        #1;
        check("m00_pulse", valid, 0);

        run_case("m01",     2'b01, 4, 4, 2, 4, 4, 1, 0, 0, 0, 5);
        run_case("m10",     2'b10, 4, 4, 2, 4, 4, 1, 0, 0, 0, 8);
        run_case("m11_all", 2'b11, 4, 4, 1, 4, 4, 1, 4, 4, 1, 0);
        run_case("m11_two", 2'b11, 4, 4, 1, 4, 4, 1, 8, 8, 0, 5);
        run_case("full",    2'b00, 0, 0, 15, 0, 0, 0, 0, 0, 0, 64);
        run_case("out_r0",  2'b00, 9, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        run_case("in_r0",   2'b00, 8, 8, 0, 0, 0, 0, 0, 0, 0, 1);

        // Second en mid-scan must be ignored.
        start(2'b00, 4, 4, 2, 0, 0, 0, 0, 0, 0);
        wait_valid(10, n);
        check("ign_lat", n, 66);
        check("ign_cnt", candidate, 13);

        // en in the valid cycle starts a new scan immediately.
        start(2'b10, 4, 4, 2, 4, 4, 1, 0, 0, 0);
        check("b2b_valid_drop", valid, 0);
        check("b2b_busy", busy, 1);
        wait_valid(-5, n);
        check("b2b_lat", n, 66);
        check("b2b_cnt", candidate, 8);

        // Result holds while idle.
        saw_valid = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (valid && i > 0) saw_valid = 1;
        end
        check("hold_cnt", candidate, 8);
        check("hold_novalid", saw_valid, 0);

        // Reset mid-scan aborts with no pulse and clears the result.
        start(2'b00, 4, 4, 2, 0, 0, 0, 0, 0, 0);
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_cand", candidate, 0);
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (valid) saw_valid = 1;
        end
        check("abort_novalid", saw_valid, 0);
        check("abort_cand_hold", candidate, 0);

        run_case("fresh", 2'b01, 4, 4, 2, 4, 4, 1, 0, 0, 0, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
